regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-side front end for the 32x32 register file: the sole driver of its write port (A3/WD3/WE3).
- Merges two result sources:
  - the in-order pipeline writeback, which cannot be back-pressured;
  - a long-latency result source (load miss, mul/div), which uses a valid/ready handshake and is buffered in a small FIFO.
- Publishes a pending-write mask so the hazard unit can stall dependent reads until buffered results retire.

Parameters:
- DEPTH, 4, long-latency FIFO entries; power of two, 2..16.
- MAX_STARVE, 3, consecutive cycles FIFO head may lose arbitration before STALL_REQ asserts; 1..15.

Ports:
- CLK  in  1  clock; FIFO and counters update on posedge; the register file samples the write port on negedge.
- RESET_N  in  1  synchronous active-low reset, sampled on posedge CLK.
- WB_VALID  in  1  pipeline writeback valid this cycle; always accepted.
- WB_A  in  5  pipeline destination register.
- WB_D  in  32  pipeline write data.
- LL_VALID  in  1  long-latency result offered.
- LL_READY  out  1  FIFO can accept; equals !full.
- LL_A  in  5  long-latency destination register.
- LL_D  in  32  long-latency write data.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.
- WE3  out  1  register file write enable.
- PENDING  out  32  bit r set if any valid FIFO entry targets register r; bit 0 is always 0.
- STALL_REQ  out  1  asks the hazard unit to insert a writeback bubble so the FIFO can drain.

Behaviour:
- Write port is combinational from inputs and FIFO head (0-cycle latency), so a write reaches the register file on the negedge of the same cycle.
- Arbitration each cycle:
  - WB_VALID=1: port = WB_A/WB_D; FIFO not popped.
  - else if FIFO non-empty: port = head entry; pop at posedge.
  - else: WE3=0, A3=0, WD3=0.
- x0 suppression: WE3 = selected_valid && (selected_addr != 0).
  - A FIFO entry addressed to x0 still pops; it just writes nothing.
- Push on posedge when LL_VALID && LL_READY.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - When full, LL_READY=0 even if a pop happens this cycle (no pass-through of readiness).
- FIFO ordering: strict in-order. Pointers are log2(DEPTH) bits, wrap modulo DEPTH; full/empty come from a separate count register, 0..DEPTH.
- PENDING is the combinational OR over valid entries of one-hot(addr).
  - Duplicate targets keep the bit set until the last matching entry pops.
  - An entry popping this cycle still shows in PENDING until the posedge.
- Starvation counter:
  - Increments at posedge when FIFO non-empty && WB_VALID; saturates at MAX_STARVE.
  - Clears on any pop or when the FIFO is empty.
  - STALL_REQ = (counter == MAX_STARVE).
- WAW ordering between sources is the hazard unit's job, via PENDING; this block does not reorder.
- Reset (RESET_N=0 at posedge), including mid-operation:
  - count, pointers and starvation counter go to 0; buffered results are discarded.
  - While RESET_N=0: LL_READY=0, STALL_REQ=0, PENDING=0, WE3=0.
  - From the first posedge with RESET_N=1: LL_READY=1.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined: adds ports FWD_A (in 5), FWD_HIT (out 1), FWD_DATA (out 32).
  - FWD_HIT=1 when some valid FIFO entry matches FWD_A and FWD_A != 0.
  - FWD_DATA is the youngest matching entry's data, else 0.
  - Purely combinational.
- Undefined: these ports and the lookup logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then WB_VALID=1, WB_A=5, WB_D=0xDEADBEEF, no LL traffic → same cycle A3=5, WD3=0xDEADBEEF, WE3=1; PENDING=0.
2. Push LL (A=7, D=0x11) while WB_VALID=0 for 2 cycles → PENDING[7]=1 for one cycle; next cycle WE3=1, A3=7, WD3=0x11; PENDING returns to 0.
3. DEPTH=4: push 4 entries while WB_VALID=1 continuously → LL_READY=0 after the 4th push; STALL_REQ=1 from the 4th cycle the head has waited (MAX_STARVE=3 saturated). Drop WB_VALID → entries retire in push order, one per cycle; LL_READY=1 after the first pop.
4. Push LL A=0, D=0xFF with WB idle → entry pops with WE3=0; PENDING[0] stays 0 throughout.
5. FIFO at 2 entries: assert RESET_N=0 for one cycle → count=0, PENDING=0, no further WE3 from the flushed entries; LL_READY=1 after release.
6. (WB_FORWARD_EN) Push A=9, D=1 then A=9, D=2 while WB busy; FWD_A=9 → FWD_HIT=1, FWD_DATA=2. FWD_A=0 → FWD_HIT=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port front end for the 32x32 register file: merges pipeline writeback with a buffered
// long-latency result FIFO and publishes a pending-write mask. Optional lookup: WB_FORWARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int MAX_STARVE = 3
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_A,
    input  logic [31:0] WB_D,
    input  logic        LL_VALID,
    output logic        LL_READY,
    input  logic [4:0]  LL_A,
    input  logic [31:0] LL_D,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic [31:0] PENDING,
    output logic        STALL_REQ
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]  FWD_A,
    output logic        FWD_HIT,
    output logic [31:0] FWD_DATA
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [3:0]    STARVE_MAX = 4'(MAX_STARVE);

    logic [4:0]    mem_a_q [DEPTH];
    logic [4:0]    mem_a_d [DEPTH];
    logic [31:0]   mem_d_q [DEPTH];
    logic [31:0]   mem_d_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          empty, full, push, pop, sel_valid;

    // LL handshake: a result transfers on the posedge where LL_VALID && LL_READY; LL_READY is
    // !full (gated by reset) and never depends on a pop in the same cycle.
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign LL_READY  = RESET_N && !full;
    assign push      = LL_VALID && LL_READY;
    assign pop       = RESET_N && !WB_VALID && !empty;
    assign STALL_REQ = RESET_N && (starve_q == STARVE_MAX);

    // Pipeline writeback always wins; the FIFO head only drives the port in idle WB slots.
    always_comb begin
        sel_valid = 1'b0;
        A3        = '0;
        WD3       = '0;
        if (RESET_N) begin
            if (WB_VALID) begin
                sel_valid = 1'b1;
                A3        = WB_A;
                WD3       = WB_D;
            end else if (!empty) begin
                sel_valid = 1'b1;
                A3        = mem_a_q[rd_ptr_q];
                WD3       = mem_d_q[rd_ptr_q];
            end
        end
        WE3 = sel_valid && (A3 != 5'd0);
    end

    always_comb begin
        logic [PW-1:0] off;
        off     = '0;
        PENDING = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (RESET_N && (CW'(off) < count_q))
                PENDING[mem_a_q[i]] = 1'b1;
        end
        PENDING[0] = 1'b0;
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the last match (youngest) supplies the data.
    always_comb begin
        logic [PW-1:0] fidx;
        fidx     = '0;
        FWD_HIT  = 1'b0;
        FWD_DATA = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = rd_ptr_q + PW'(k);
            if (RESET_N && (FWD_A != 5'd0) && (CW'(k) < count_q) && (mem_a_q[fidx] == FWD_A)) begin
                FWD_HIT  = 1'b1;
                FWD_DATA = mem_d_q[fidx];
            end
        end
    end
`endif

    always_comb begin
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = LL_A;
            mem_d_d[wr_ptr_q] = LL_D;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (empty || pop)
            starve_d = '0;
        else if (WB_VALID && (starve_q != STARVE_MAX))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge CLK) begin
        mem_a_q <= mem_a_d;
        mem_d_q <= mem_d_d;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int MAX_STARVE = 3;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        WB_VALID;
    logic [4:0]  WB_A;
    logic [31:0] WB_D;
    logic        LL_VALID;
    logic        LL_READY;
    logic [4:0]  LL_A;
    logic [31:0] LL_D;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] PENDING;
    logic        STALL_REQ;
`ifdef WB_FORWARD_EN
    logic [4:0]  FWD_A;
    logic        FWD_HIT;
    logic [31:0] FWD_DATA;
`endif

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .WB_VALID(WB_VALID), .WB_A(WB_A), .WB_D(WB_D),
        .LL_VALID(LL_VALID), .LL_READY(LL_READY), .LL_A(LL_A), .LL_D(LL_D),
        .A3(A3), .WD3(WD3), .WE3(WE3), .PENDING(PENDING), .STALL_REQ(STALL_REQ)
`ifdef WB_FORWARD_EN
        , .FWD_A(FWD_A), .FWD_HIT(FWD_HIT), .FWD_DATA(FWD_DATA)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: FIFO contents as {addr, data} in arrival order, plus a starvation count.
    logic [36:0] exp_q[$];
    int          starve;
    int          nvec = 0;
    int          nerr = 0;
    string       phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic llv, input logic [4:0] lla, input logic [31:0] lld);
        logic        e_ready, e_stall, e_we, push, pop;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_pend;
        RESET_N  = rn;
        WB_VALID = wbv; WB_A = wba; WB_D = wbd;
        LL_VALID = llv; LL_A = lla; LL_D = lld;
        @(negedge CLK);
        e_ready = rn && (exp_q.size() < DEPTH);
        e_stall = rn && (starve == MAX_STARVE);
        e_pend  = '0;
        if (rn)
            foreach (exp_q[i]) e_pend[exp_q[i][36:32]] = 1'b1;
        e_pend[0] = 1'b0;
        e_a = '0; e_d = '0;
        if (wbv) begin
            e_a = wba; e_d = wbd;
        end else if (exp_q.size() > 0) begin
            e_a = exp_q[0][36:32]; e_d = exp_q[0][31:0];
        end
        e_we = rn && (wbv || exp_q.size() > 0) && (e_a != 5'd0);
        chk("LL_READY", 32'(LL_READY), 32'(e_ready));
        chk("STALL_REQ", 32'(STALL_REQ), 32'(e_stall));
        chk("PENDING", PENDING, e_pend);
        chk("WE3", 32'(WE3), 32'(e_we));
        if (rn) begin
            chk("A3", 32'(A3), 32'(e_a));
            chk("WD3", WD3, e_d);
        end
`ifdef WB_FORWARD_EN
        begin
            logic        e_hit;
            logic [31:0] e_fd;
            e_hit = 1'b0; e_fd = '0;
            if (rn && FWD_A != 5'd0)
                foreach (exp_q[i])
                    if (exp_q[i][36:32] == FWD_A) begin
                        e_hit = 1'b1; e_fd = exp_q[i][31:0];
                    end
            chk("FWD_HIT", 32'(FWD_HIT), 32'(e_hit));
            chk("FWD_DATA", FWD_DATA, e_fd);
        end
`endif
        @(posedge CLK);
        if (!rn) begin
            exp_q.delete();
            starve = 0;
        end else begin
            push = llv && e_ready;
            pop  = !wbv && (exp_q.size() > 0);
            if (exp_q.size() == 0 || pop)
                starve = 0;
            else if (wbv && starve < MAX_STARVE)
                starve++;
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({lla, lld});
        end
        #1;
    endtask

    initial begin
        RESET_N = 1'b0; WB_VALID = 1'b0; WB_A = '0; WB_D = '0;
        LL_VALID = 1'b0; LL_A = '0; LL_D = '0;
`ifdef WB_FORWARD_EN
        FWD_A = '0;
`endif
        starve = 0;
        @(posedge CLK); #1;

        phase = "reset";
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 32'h1, 1, 4, 32'h2);

        phase = "wb_only";
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);

        phase = "ll_single";
        step(1, 0, 0, 0, 1, 7, 32'h11);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        phase = "fill_starve";
        for (int i = 0; i < 5; i++)
            step(1, 1, 5'(i + 1), $urandom, 1, 5'(10 + i), 32'(100 + i));
        step(1, 1, 2, $urandom, 0, 0, 0);
        phase = "drain";
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 0, 0, 0);

        phase = "x0_entry";
        step(1, 0, 0, 0, 1, 0, 32'hFF);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        phase = "mid_reset";
        step(1, 1, 1, 32'h5, 1, 20, 32'hA);
        step(1, 1, 1, 32'h6, 1, 21, 32'hB);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

`ifdef WB_FORWARD_EN
        phase = "forward";
        FWD_A = 5'd9;
        step(1, 1, 3, 32'h7, 1, 9, 32'h1);
        step(1, 1, 3, 32'h7, 1, 9, 32'h2);
        step(1, 1, 3, 32'h7, 0, 0, 0);
        FWD_A = 5'd0;
        step(1, 1, 3, 32'h7, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, 0);
`endif

        phase = "random";
        for (int i = 0; i < 400; i++) begin
`ifdef WB_FORWARD_EN
            FWD_A = 5'($urandom_range(0, 7));
`endif
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 99) < 55),
                 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 45),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
